// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the multi-channel debounce controller.
// Latency: none (package only).
// Backpressure: none (package only).
package debounce_pkg;

  // Controller state; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;

  localparam int DEB_N      = 4;
  localparam int DEB_SETTLE = 4;
  localparam int DEB_CW     = 3;

  // Next channel index after i, wrapping N-1 back to 0.
  function automatic int wrap_next(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/debounce_arbiter_rr.sv
// Round-robin picker: first set request at or after ptr, searching cyclically.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk N positions starting at ptr; the first hit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      logic [IW-1:0] ci;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!any && pending[ci]) begin
        any        = 1'b1;
        idx        = ci;
        onehot[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_arbiter.sv
// Debounces N raw inputs with one shared settle timer, granted round-robin.
// Latency: SETTLE+2 edges from raw sampling to stable update when uncontended.
// Backpressure: none; ungranted channels simply wait (DEBOUNCE_ARB_EVENT_EN adds evt).
module debounce_arbiter
  import debounce_pkg::*;
#(
  parameter int N      = DEB_N,
  parameter int SETTLE = DEB_SETTLE,
  parameter int CW     = DEB_CW
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [N-1:0] raw,
  output logic [N-1:0] stable,
  output logic [N-1:0] grant,
  output logic         busy
`ifdef DEBOUNCE_ARB_EVENT_EN
  ,
  output logic [N-1:0] evt
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_t        state, state_n;
  logic [N-1:0]  raw_q;
  logic [N-1:0]  pending;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] g, g_n;
  logic [N-1:0]  g_oh, g_oh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          commit;

  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  // A channel needs attention whenever its sampled level disagrees with its debounced level.
  assign pending = raw_q ^ stable;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .pending (pending),
    .ptr     (ptr),
    .onehot  (pick_oh),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // Next-state logic: pick in IDLE, count consecutive mismatch in SETTLE, toggle in COMMIT.
  always_comb begin
    state_n = state;
    g_n     = g;
    g_oh_n  = g_oh;
    cnt_n   = cnt;
    ptr_n   = ptr;
    commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          g_n     = pick_idx;
          g_oh_n  = pick_oh;
          cnt_n   = '0;
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!pending[g]) begin
          // Bounce: give up and let the next channel have the timer.
          ptr_n   = IW'(wrap_next(int'(g), N));
          state_n = ST_IDLE;
        end else if (cnt == SETTLE_LAST) begin
          state_n = ST_COMMIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_COMMIT: begin
        // Unconditional: the level was already qualified during SETTLE.
        commit  = 1'b1;
        ptr_n   = IW'(wrap_next(int'(g), N));
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Control registers; clear wins over every transition including a pending commit.
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
      raw_q <= '0;
      ptr   <= '0;
      g     <= '0;
      g_oh  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      raw_q <= raw;
      ptr   <= ptr_n;
      g     <= g_n;
      g_oh  <= g_oh_n;
      cnt   <= cnt_n;
    end
  end

  // Debounced levels: only the granted bit toggles, and only on commit.
  always_ff @(posedge clk) begin
    if (clear) begin
      stable <= '0;
    end else if (commit) begin
      stable[g] <= ~stable[g];
    end
  end

`ifdef DEBOUNCE_ARB_EVENT_EN
  // One-cycle pulse aligned with the first cycle the new stable value is visible.
  always_ff @(posedge clk) begin
    if (clear) begin
      evt <= '0;
    end else begin
      evt <= '0;
      if (commit) evt[g] <= 1'b1;
    end
  end
`endif

  // Grant follows the latched channel for as long as it owns the timer.
  always_comb begin
    grant = '0;
    if (state == ST_SETTLE || state == ST_COMMIT) grant = g_oh;
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter: stimulus queues expectations, a monitor checks them.
// Latency: expectations are tied to absolute clock-cycle numbers.
// Backpressure: n/a.
module tb_debounce_arbiter;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] raw;
  logic [3:0] stable;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] evt_s;

  debounce_arbiter #(.N(4), .SETTLE(4), .CW(3)) dut (
    .clk    (clk),
    .clear  (clear),
    .raw    (raw),
    .stable (stable),
    .grant  (grant),
    .busy   (busy)
`ifdef DEBOUNCE_ARB_EVENT_EN
    ,
    .evt    (evt_s)
`endif
  );

`ifndef DEBOUNCE_ARB_EVENT_EN
  assign evt_s = '0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected stable change (and event) at a given cycle.
  typedef struct {
    int         c;
    logic [3:0] stb;
    logic [3:0] ev;
  } commit_t;

  // Expected grant/busy/stable snapshot at a given cycle.
  typedef struct {
    int         c;
    logic [3:0] gnt;
    logic       bsy;
    logic [3:0] stb;
  } probe_t;

  commit_t cq[$];
  probe_t  pq[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  logic    done     = 1'b0;
  logic [3:0] prev_stb = 4'b0000;

  task automatic probe(input int c, input logic [3:0] gnt, input logic bsy, input logic [3:0] stb);
    probe_t p;
    p.c = c; p.gnt = gnt; p.bsy = bsy; p.stb = stb;
    pq.push_back(p);
  endtask

  task automatic expect_commit(input int c, input logic [3:0] stb, input logic [3:0] ev);
    commit_t e;
    e.c = c; e.stb = stb; e.ev = ev;
    cq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    probe_t  p;
    commit_t e;
    while (pq.size() > 0 && pq[0].c <= cyc) begin
      p = pq.pop_front();
      n_checks++;
      if (grant !== p.gnt) begin
        n_fail++;
        $display("FAIL grant@%0d: got %b expected %b", p.c, grant, p.gnt);
      end
      n_checks++;
      if (busy !== p.bsy) begin
        n_fail++;
        $display("FAIL busy@%0d: got %b expected %b", p.c, busy, p.bsy);
      end
      n_checks++;
      if (stable !== p.stb) begin
        n_fail++;
        $display("FAIL stable@%0d: got %b expected %b", p.c, stable, p.stb);
      end
    end
    if (stable !== prev_stb || evt_s !== 4'b0000) begin
      if (cq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output@%0d: stable %b event %b, expected no change", cyc, stable, evt_s);
      end else begin
        e = cq.pop_front();
        n_checks++;
        if (cyc != e.c) begin
          n_fail++;
          $display("FAIL commit_cycle: got %0d expected %0d", cyc, e.c);
        end
        n_checks++;
        if (stable !== e.stb) begin
          n_fail++;
          $display("FAIL commit_stable@%0d: got %b expected %b", cyc, stable, e.stb);
        end
`ifdef DEBOUNCE_ARB_EVENT_EN
        n_checks++;
        if (evt_s !== e.ev) begin
          n_fail++;
          $display("FAIL commit_event@%0d: got %b expected %b", cyc, evt_s, e.ev);
        end
`endif
      end
    end
    prev_stb = stable;
    if (done) begin
      n_checks++;
      if (cq.size() != 0 || pq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_expectations: got %0d commits %0d probes expected 0 0", cq.size(), pq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish by cycle 60");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    // Reset with all raw inputs high: everything held at zero.
    clear = 1'b1;
    raw   = 4'b1111;
    probe(1, 4'b0000, 1'b0, 4'b0000);
    probe(2, 4'b0000, 1'b0, 4'b0000);
    tick(); tick();
    clear = 1'b0;
    e0 = cyc + 1;
    probe(e0,     4'b0000, 1'b0, 4'b0000);
    probe(e0 + 1, 4'b0001, 1'b1, 4'b0000);  // channel 0 first after reset
    repeat (2) tick();
    clear = 1'b1;                             // clear mid-SETTLE: no commit
    probe(cyc + 1, 4'b0000, 1'b0, 4'b0000);
    tick();
    clear = 1'b0;
    raw   = 4'b0000;

    // Single edge on channel 0.
    raw = 4'b0001;
    e0  = cyc + 1;
    probe(e0,     4'b0000, 1'b0, 4'b0000);
    probe(e0 + 1, 4'b0001, 1'b1, 4'b0000);
    probe(e0 + 5, 4'b0001, 1'b1, 4'b0000);
    probe(e0 + 6, 4'b0000, 1'b0, 4'b0001);
    expect_commit(e0 + 6, 4'b0001, 4'b0001);
    repeat (7) tick();

    // Bounce on channel 2: high for two samples, then low.
    raw = 4'b0101;
    e0  = cyc + 1;
    probe(e0 + 1, 4'b0100, 1'b1, 4'b0001);
    tick(); tick();
    raw = 4'b0001;
    probe(e0 + 2, 4'b0100, 1'b1, 4'b0001);
    probe(e0 + 3, 4'b0000, 1'b0, 4'b0001);
    tick(); tick();

    // Pointer now at 3; channels 0 (falling) and 3 pending: 3 wins, then wraps to 0.
    raw = 4'b1000;
    e0  = cyc + 1;
    probe(e0 + 1, 4'b1000, 1'b1, 4'b0001);
    expect_commit(e0 + 6, 4'b1001, 4'b1000);
    probe(e0 + 7, 4'b0001, 1'b1, 4'b1001);
    expect_commit(e0 + 12, 4'b1000, 4'b0001);
    probe(e0 + 13, 4'b0000, 1'b0, 4'b1000);
    repeat (14) tick();

    // Contention from a fresh clear: channels 1 and 3 with ptr=0.
    clear = 1'b1;
    raw   = 4'b0000;
    expect_commit(cyc + 1, 4'b0000, 4'b0000);
    tick();
    clear = 1'b0;
    raw   = 4'b1010;
    e0    = cyc + 1;
    probe(e0 + 1, 4'b0010, 1'b1, 4'b0000);
    expect_commit(e0 + 6, 4'b0010, 4'b0010);
    probe(e0 + 7, 4'b1000, 1'b1, 4'b0010);
    expect_commit(e0 + 12, 4'b1010, 4'b1000);
    repeat (13) tick();

    // Clear at E3 during channel 0 SETTLE, then a full re-settle.
    clear = 1'b1;
    raw   = 4'b0000;
    expect_commit(cyc + 1, 4'b0000, 4'b0000);
    tick();
    clear = 1'b0;
    raw   = 4'b0001;
    e0    = cyc + 1;
    probe(e0 + 1, 4'b0001, 1'b1, 4'b0000);
    probe(e0 + 2, 4'b0001, 1'b1, 4'b0000);
    repeat (3) tick();
    clear = 1'b1;
    probe(e0 + 3, 4'b0000, 1'b0, 4'b0000);
    tick();
    clear = 1'b0;
    e0    = cyc + 1;
    probe(e0 + 1, 4'b0001, 1'b1, 4'b0000);
    expect_commit(e0 + 6, 4'b0001, 4'b0001);
    probe(e0 + 7, 4'b0000, 1'b0, 4'b0001);
    repeat (8) tick();

    done = 1'b1;
  end

endmodule
